// File: rtl/cpu_mem_responder_if.sv
// Request/response channel between the CPU memory port and the memory responder.
// The CPU drives requests and resp_ready; the responder drives req_ready and the response.
interface cpu_mem_responder_if #(
  parameter int ADDR_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic              req_wr;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic [3:0]        req_be;
  logic              resp_valid;
  logic              resp_ready;
  logic [31:0]       resp_rdata;
  logic              resp_err;

  modport master (
    output req_valid, req_wr, req_addr, req_wdata, req_be, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_wr, req_addr, req_wdata, req_be, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/cpu_mem_responder.sv
// Word-addressed RAM responder for the multicycle CPU.
// One request at a time: accept in IDLE, count wait states in WAIT,
// perform the RAM access on the edge entering RESP, hold the response until taken.
module cpu_mem_responder #(
  parameter int ADDR_W      = 32,
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_CYCLES = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  cpu_mem_responder_if.slave   bus
);
  localparam int IDX_W = $clog2(DEPTH_WORDS);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t            state_r, state_s;
  logic [3:0]        cnt_r;
  logic              wr_r;
  logic [ADDR_W-1:0] addr_r;
  logic [31:0]       wdata_r;
  logic [3:0]        be_r;
  logic              resp_valid_r;
  logic [31:0]       resp_rdata_r;
  logic              resp_err_r;

  logic [31:0] mem [DEPTH_WORDS];

  logic              accept_s;
  logic              enter_resp_s;
  logic              acc_wr_s;
  logic [ADDR_W-1:0] acc_addr_s;
  logic [31:0]       acc_wdata_s;
  logic [3:0]        acc_be_s;
  logic              acc_err_s;
  logic [IDX_W-1:0]  acc_idx_s;

  // Misaligned or beyond the last RAM word.
  function automatic logic addr_err(input logic [ADDR_W-1:0] a);
    logic [ADDR_W-1:0] word_v;
    word_v = {2'b00, a[ADDR_W-1:2]};
    return (a[1:0] != 2'b00) || (word_v >= ADDR_W'(DEPTH_WORDS));
  endfunction

  assign accept_s       = bus.req_valid && (state_r == ST_IDLE);
  assign bus.req_ready  = (state_r == ST_IDLE);
  assign bus.resp_valid = resp_valid_r;
  assign bus.resp_rdata = resp_rdata_r;
  assign bus.resp_err   = resp_err_r;

  // Access fields come straight from the bus when entering RESP from IDLE (zero wait states).
  always_comb begin
    acc_wr_s    = wr_r;
    acc_addr_s  = addr_r;
    acc_wdata_s = wdata_r;
    acc_be_s    = be_r;
    if (state_r == ST_IDLE) begin
      acc_wr_s    = bus.req_wr;
      acc_addr_s  = bus.req_addr;
      acc_wdata_s = bus.req_wdata;
      acc_be_s    = bus.req_be;
    end else begin
      acc_wr_s    = wr_r;
    end
    acc_err_s = addr_err(acc_addr_s);
    acc_idx_s = acc_addr_s[IDX_W+1:2];
  end

  // Next-state decode; enter_resp_s marks the edge that performs the RAM access.
  always_comb begin
    state_s      = state_r;
    enter_resp_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          if (WAIT_CYCLES == 0) begin
            state_s      = ST_RESP;
            enter_resp_s = 1'b1;
          end else begin
            state_s      = ST_WAIT;
          end
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (cnt_r == 4'd1) begin
          state_s      = ST_RESP;
          enter_resp_s = 1'b1;
        end else begin
          state_s = ST_WAIT;
        end
      end
      ST_RESP: begin
        if (bus.resp_ready) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_RESP;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Latch the accepted request and run the wait-state counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r   <= 4'd0;
      wr_r    <= 1'b0;
      addr_r  <= '0;
      wdata_r <= 32'd0;
      be_r    <= 4'd0;
    end else if (accept_s) begin
      cnt_r   <= 4'(WAIT_CYCLES);
      wr_r    <= bus.req_wr;
      addr_r  <= bus.req_addr;
      wdata_r <= bus.req_wdata;
      be_r    <= bus.req_be;
    end else if (state_r == ST_WAIT) begin
      cnt_r   <= cnt_r - 4'd1;
    end
  end

  // Response registers: loaded on entry to RESP, cleared on the handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp_valid_r <= 1'b0;
      resp_rdata_r <= 32'd0;
      resp_err_r   <= 1'b0;
    end else if (enter_resp_s) begin
      resp_valid_r <= 1'b1;
      resp_err_r   <= acc_err_s;
      resp_rdata_r <= (!acc_wr_s && !acc_err_s) ? mem[acc_idx_s] : 32'd0;
    end else if ((state_r == ST_RESP) && bus.resp_ready) begin
      resp_valid_r <= 1'b0;
      resp_rdata_r <= 32'd0;
      resp_err_r   <= 1'b0;
    end
  end

  // RAM byte-lane write; contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (rst_n && enter_resp_s && acc_wr_s && !acc_err_s) begin
      for (int i = 0; i < 4; i++) begin
        if (acc_be_s[i]) begin
          mem[acc_idx_s][8*i +: 8] <= acc_wdata_s[8*i +: 8];
        end
      end
    end
  end
endmodule

// File: tb/tb_cpu_mem_responder.sv
// Directed bench for cpu_mem_responder: three instances with 0, 1 and 15 wait states
// share one set of request drivers; sel chooses which one sees req_valid.
module tb_cpu_mem_responder;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_wr = 1'b0;
  logic [31:0] req_addr = 32'd0;
  logic [31:0] req_wdata = 32'd0;
  logic [3:0]  req_be = 4'd0;
  logic        resp_ready = 1'b1;
  int          sel = 1;
  int          tests = 0;
  int          fails = 0;

  logic        m_req_ready, m_resp_valid, m_resp_err;
  logic [31:0] m_resp_rdata;

  cpu_mem_responder_if #(.ADDR_W(32)) b0 ();
  cpu_mem_responder_if #(.ADDR_W(32)) b1 ();
  cpu_mem_responder_if #(.ADDR_W(32)) b15 ();

  assign b0.req_valid  = req_valid && (sel == 0);
  assign b1.req_valid  = req_valid && (sel == 1);
  assign b15.req_valid = req_valid && (sel == 15);
  assign b0.req_wr  = req_wr;    assign b1.req_wr  = req_wr;    assign b15.req_wr  = req_wr;
  assign b0.req_addr = req_addr; assign b1.req_addr = req_addr; assign b15.req_addr = req_addr;
  assign b0.req_wdata = req_wdata; assign b1.req_wdata = req_wdata; assign b15.req_wdata = req_wdata;
  assign b0.req_be = req_be;     assign b1.req_be = req_be;     assign b15.req_be = req_be;
  assign b0.resp_ready = resp_ready; assign b1.resp_ready = resp_ready; assign b15.resp_ready = resp_ready;

  assign m_req_ready  = (sel == 0) ? b0.req_ready  : (sel == 1) ? b1.req_ready  : b15.req_ready;
  assign m_resp_valid = (sel == 0) ? b0.resp_valid : (sel == 1) ? b1.resp_valid : b15.resp_valid;
  assign m_resp_err   = (sel == 0) ? b0.resp_err   : (sel == 1) ? b1.resp_err   : b15.resp_err;
  assign m_resp_rdata = (sel == 0) ? b0.resp_rdata : (sel == 1) ? b1.resp_rdata : b15.resp_rdata;

  cpu_mem_responder #(.ADDR_W(32), .DEPTH_WORDS(1024), .WAIT_CYCLES(0))  u0  (.clk(clk), .rst_n(rst_n), .bus(b0));
  cpu_mem_responder #(.ADDR_W(32), .DEPTH_WORDS(1024), .WAIT_CYCLES(1))  u1  (.clk(clk), .rst_n(rst_n), .bus(b1));
  cpu_mem_responder #(.ADDR_W(32), .DEPTH_WORDS(1024), .WAIT_CYCLES(15)) u15 (.clk(clk), .rst_n(rst_n), .bus(b15));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One full transaction on the selected instance with resp_ready held high.
  // lat counts edges from the accept edge (inclusive) to the edge that raised resp_valid.
  task automatic xact(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [3:0] be, output logic [31:0] rdata, output logic err,
                      output int lat);
    req_valid = 1'b1; req_wr = wr; req_addr = addr; req_wdata = wdata; req_be = be;
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 1;
    while (!m_resp_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    rdata = m_resp_rdata;
    err   = m_resp_err;
    @(posedge clk); #1;
    chk("hs_clear_valid", {31'd0, m_resp_valid}, 32'd0);
  endtask

  logic [31:0] rd;
  logic        er;
  int          lt;

  initial begin
    // Reset state
    #2;
    chk("rst_resp_valid", {31'd0, b1.resp_valid}, 32'd0);
    chk("rst_resp_rdata", b1.resp_rdata, 32'd0);
    chk("rst_resp_err", {31'd0, b1.resp_err}, 32'd0);
    chk("rst_req_ready", {31'd0, b1.req_ready}, 32'd1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Full write then read, one wait state
    sel = 1;
    xact(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, rd, er, lt);
    chk("t1_wr_lat", lt, 32'd2);
    chk("t1_wr_err", {31'd0, er}, 32'd0);
    chk("t1_wr_rdata", rd, 32'd0);
    xact(1'b0, 32'h10, 32'h0, 4'h0, rd, er, lt);
    chk("t1_rd_lat", lt, 32'd2);
    chk("t1_rd_data", rd, 32'hDEADBEEF);

    // Partial write merges with existing bytes
    xact(1'b1, 32'h10, 32'h00001122, 4'b0011, rd, er, lt);
    xact(1'b0, 32'h10, 32'h0, 4'h0, rd, er, lt);
    chk("t2_merge", rd, 32'hDEAD1122);

    // Errors and boundaries
    xact(1'b0, 32'h13, 32'h0, 4'h0, rd, er, lt);
    chk("t3_mis_err", {31'd0, er}, 32'd1);
    chk("t3_mis_rdata", rd, 32'd0);
    xact(1'b0, 32'h1000, 32'h0, 4'h0, rd, er, lt);
    chk("t3_oor_err", {31'd0, er}, 32'd1);
    chk("t3_oor_rdata", rd, 32'd0);
    xact(1'b0, 32'hFFC, 32'h0, 4'h0, rd, er, lt);
    chk("t3_last_word_err", {31'd0, er}, 32'd0);
    xact(1'b1, 32'h12, 32'hFFFFFFFF, 4'hF, rd, er, lt);
    chk("t3_mis_wr_err", {31'd0, er}, 32'd1);
    xact(1'b1, 32'h10, 32'h12345678, 4'h0, rd, er, lt);
    chk("t3_be0_err", {31'd0, er}, 32'd0);
    xact(1'b0, 32'h10, 32'h0, 4'h0, rd, er, lt);
    chk("t3_unchanged", rd, 32'hDEAD1122);

    // Backpressure: response held, held req_valid (a write) must not be accepted
    resp_ready = 1'b0;
    req_valid = 1'b1; req_wr = 1'b0; req_addr = 32'h10; req_be = 4'h0;
    @(posedge clk); #1;
    req_wr = 1'b1; req_wdata = 32'h0; req_be = 4'hF;
    lt = 0;
    while (!m_resp_valid && lt < 40) begin
      @(posedge clk); #1;
      lt++;
    end
    for (int i = 0; i < 5; i++) begin
      chk("t4_hold_valid", {31'd0, m_resp_valid}, 32'd1);
      chk("t4_hold_rdata", m_resp_rdata, 32'hDEAD1122);
      chk("t4_hold_err", {31'd0, m_resp_err}, 32'd0);
      chk("t4_hold_ready", {31'd0, m_req_ready}, 32'd0);
      @(posedge clk); #1;
    end
    req_valid = 1'b0;
    resp_ready = 1'b1;
    @(posedge clk); #1;
    chk("t4_rel_valid", {31'd0, m_resp_valid}, 32'd0);
    chk("t4_rel_ready", {31'd0, m_req_ready}, 32'd1);
    xact(1'b0, 32'h10, 32'h0, 4'h0, rd, er, lt);
    chk("t4_no_overwrite", rd, 32'hDEAD1122);

    // Latency extremes
    sel = 0;
    xact(1'b1, 32'h40, 32'hCAFEF00D, 4'hF, rd, er, lt);
    chk("t5_w0_wr_lat", lt, 32'd1);
    xact(1'b0, 32'h40, 32'h0, 4'h0, rd, er, lt);
    chk("t5_w0_rd_lat", lt, 32'd1);
    chk("t5_w0_rd_data", rd, 32'hCAFEF00D);
    sel = 15;
    xact(1'b1, 32'h44, 32'hA5A55A5A, 4'hF, rd, er, lt);
    chk("t5_w15_wr_lat", lt, 32'd16);
    xact(1'b0, 32'h44, 32'h0, 4'h0, rd, er, lt);
    chk("t5_w15_rd_lat", lt, 32'd16);
    chk("t5_w15_rd_data", rd, 32'hA5A55A5A);

    // Reset during WAIT discards the pending write
    sel = 1;
    xact(1'b1, 32'h20, 32'h0, 4'hF, rd, er, lt);
    req_valid = 1'b1; req_wr = 1'b1; req_addr = 32'h20; req_wdata = 32'h55AA55AA; req_be = 4'hF;
    @(posedge clk); #1;
    req_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("t6_rst_valid", {31'd0, m_resp_valid}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("t6_rel_ready", {31'd0, m_req_ready}, 32'd1);
    chk("t6_rel_valid", {31'd0, m_resp_valid}, 32'd0);
    xact(1'b0, 32'h20, 32'h0, 4'h0, rd, er, lt);
    chk("t6_ram_kept", rd, 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
